// File: rtl/touch_pulse_gen.sv
// Synthesises an active-low touch waveform (press bounce, hold, release bounce, gap) on one pin.
// state | meaning: IDLE wait start | B_IN press bounce | HOLD active | B_OUT release bounce | GAP idle gap
module touch_pulse_gen #(
  parameter int CNT_W        = 16,
  parameter int BOUNCE_EDGES = 2,
  parameter int BOUNCE_TICKS = 3,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [CNT_W-1:0] gap_len,
  output logic             touch_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       press_cnt
);

  localparam bit HAS_BOUNCE = (BOUNCE_EDGES > 0);
  localparam int PH_W       = HAS_BOUNCE ? $clog2(2 * BOUNCE_EDGES) : 1;
  localparam int LAST_PH    = HAS_BOUNCE ? 2 * BOUNCE_EDGES - 1 : 0;
  localparam logic [PH_W-1:0]  LAST_PH_V = PH_W'(LAST_PH);
  localparam logic [CNT_W-1:0] BT_V      = CNT_W'(BOUNCE_TICKS);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_B_IN, S_HOLD, S_B_OUT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             touch_q, touch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       press_q, press_d;
  logic             active_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d  = (hold_len == '0) ? ONE_V : hold_len;
          gap_d   = gap_len;
          phase_d = '0;
          if (HAS_BOUNCE) begin
            state_d = S_B_IN;
            cnt_d   = BT_V;
          end else begin
            state_d = S_HOLD;
            cnt_d   = hold_d;
          end
        end
      end
      S_B_IN: begin
        if (cnt_q == ONE_V) begin
          if (phase_q == LAST_PH_V) begin
            state_d = S_HOLD;
            cnt_d   = hold_q;
          end else begin
            phase_d = phase_q + PH_W'(1);
            cnt_d   = BT_V;
          end
        end else begin
          cnt_d = cnt_q - ONE_V;
        end
      end
      S_HOLD: begin
        if (cnt_q == ONE_V) begin
          if (HAS_BOUNCE) begin
            state_d = S_B_OUT;
            phase_d = '0;
            cnt_d   = BT_V;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
            cnt_d   = gap_q;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE_V;
        end
      end
      S_B_OUT: begin
        if (cnt_q == ONE_V) begin
          if (phase_q != LAST_PH_V) begin
            phase_d = phase_q + PH_W'(1);
            cnt_d   = BT_V;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
            cnt_d   = gap_q;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE_V;
        end
      end
      S_GAP: begin
        if (cnt_q == ONE_V) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_V;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides any advance but never applies in IDLE, so start keeps priority there
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    active_d = (state_d == S_HOLD) ||
               ((state_d == S_B_IN) && !phase_d[0]) ||
               ((state_d == S_B_OUT) && phase_d[0]);
    touch_d  = active_d ? ~IDLE_LEVEL : IDLE_LEVEL;
    busy_d   = (state_d != S_IDLE);
    press_d  = press_q;
    if ((state_d == S_HOLD) && (state_q != S_HOLD)) press_d = press_q + 8'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      phase_q <= '0;
      touch_q <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      press_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
      touch_q <= touch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      press_q <= press_d;
    end
  end

  assign touch_out = touch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign press_cnt = press_q;

endmodule

// File: tb/tb_touch_pulse_gen.sv
// Scoreboard bench: a cycle model pushes expected (touch, busy, done) per cycle; tasks pop and compare.
module tb_touch_pulse_gen;

  typedef struct packed {logic t; logic b; logic d;} exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, abort0, start1, abort1;
  logic [15:0] hold0, gap0, hold1, gap1;
  logic        touch0, busy0, done0, touch1, busy1, done1;
  logic [7:0]  press0, press1;
  logic [7:0]  ep0, ep1;
  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  touch_pulse_gen u0 (
    .sys_clk(clk), .sys_rst(rst), .start(start0), .abort(abort0),
    .hold_len(hold0), .gap_len(gap0), .touch_out(touch0), .busy(busy0),
    .done(done0), .press_cnt(press0)
  );

  touch_pulse_gen #(.BOUNCE_EDGES(0)) u1 (
    .sys_clk(clk), .sys_rst(rst), .start(start1), .abort(abort1),
    .hold_len(hold1), .gap_len(gap1), .touch_out(touch1), .busy(busy1),
    .done(done1), .press_cnt(press1)
  );

  function automatic void push_one(logic t, logic b, logic d);
    exp_t x;
    x.t = t; x.b = b; x.d = d;
    sb.push_back(x);
  endfunction

  // Reference waveform, bounce phase length fixed at 3 cycles
  function automatic void push_seq(int be, int hold, int gap);
    int h = (hold == 0) ? 1 : hold;
    for (int p = 0; p < 2 * be; p++)
      for (int c = 0; c < 3; c++) push_one((p % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < h; c++) push_one(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 2 * be; p++)
      for (int c = 0; c < 3; c++) push_one((p % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < gap; c++) push_one(1'b1, 1'b1, 1'b0);
    push_one(1'b1, 1'b0, 1'b1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
    hold0 = 0; gap0 = 0; hold1 = 0; gap1 = 0;
    ep0 = 0; ep1 = 0;
    #2;
    total++;
    if ({touch0, busy0, done0, press0} !== {3'b100, 8'd0}) begin
      bad++; $display("FAIL reset_u0 got=%b/%0d exp=100/0", {touch0, busy0, done0}, press0);
    end
    total++;
    if ({touch1, busy1, done1, press1} !== {3'b100, 8'd0}) begin
      bad++; $display("FAIL reset_u1 got=%b/%0d exp=100/0", {touch1, busy1, done1}, press1);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_edges();
    int i = 0;
    hold1 = 16'd5; gap1 = 16'd3;
    push_seq(0, 5, 3); ep1 = ep1 + 8'd1;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if ({touch1, busy1, done1} !== e) begin
        bad++; $display("FAIL clean_wave cyc=%0d got=%b exp=%b", i + 1, {touch1, busy1, done1}, e);
      end
      i++; @(negedge clk);
    end
    total++;
    if (press1 !== ep1) begin bad++; $display("FAIL clean_press got=%0d exp=%0d", press1, ep1); end
  endtask

  task automatic test_bounce();
    int i = 0;
    hold0 = 16'd4; gap0 = 16'd0;
    push_seq(2, 4, 0); push_one(1'b1, 1'b0, 1'b0); push_one(1'b1, 1'b0, 1'b0);
    ep0 = ep0 + 8'd1;
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if ({touch0, busy0, done0} !== e) begin
        bad++; $display("FAIL bounce_wave cyc=%0d got=%b exp=%b", i + 1, {touch0, busy0, done0}, e);
      end
      i++; @(negedge clk);
    end
    total++;
    if (press0 !== ep0) begin bad++; $display("FAIL bounce_press got=%0d exp=%0d", press0, ep0); end
  endtask

  task automatic test_zero_hold_ignore_start();
    int i = 0;
    hold0 = 16'd0; gap0 = 16'd2;
    push_seq(2, 0, 2);
    for (int c = 0; c < 4; c++) push_one(1'b1, 1'b0, 1'b0);
    ep0 = ep0 + 8'd1;
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if ({touch0, busy0, done0} !== e) begin
        bad++; $display("FAIL zero_hold cyc=%0d got=%b exp=%b", i + 1, {touch0, busy0, done0}, e);
      end
      if (i == 5) begin start0 = 1'b1; hold0 = 16'd9; gap0 = 16'd7; end
      if (i == 6) start0 = 1'b0;
      i++; @(negedge clk);
    end
    total++;
    if (press0 !== ep0) begin bad++; $display("FAIL zero_hold_press got=%0d exp=%0d", press0, ep0); end
  endtask

  task automatic test_abort();
    int i = 0;
    hold0 = 16'd10; gap0 = 16'd2;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++) push_one(p[0], 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) push_one(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 30; c++) push_one(1'b1, 1'b0, 1'b0);
    ep0 = ep0 + 8'd1;
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if ({touch0, busy0, done0} !== e) begin
        bad++; $display("FAIL abort_wave cyc=%0d got=%b exp=%b", i + 1, {touch0, busy0, done0}, e);
      end
      abort0 = (i == 14);
      i++; @(negedge clk);
    end
    total++;
    if (press0 !== ep0) begin bad++; $display("FAIL abort_press got=%0d exp=%0d", press0, ep0); end
  endtask

  task automatic test_async_reset();
    int i = 0;
    hold0 = 16'd2; gap0 = 16'd5;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++) push_one(p[0], 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) push_one(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) push_one(1'b1, 1'b1, 1'b0);
    push_one(1'b0, 1'b1, 1'b0);
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if ({touch0, busy0, done0} !== e) begin
        bad++; $display("FAIL rst_pre cyc=%0d got=%b exp=%b", i + 1, {touch0, busy0, done0}, e);
      end
      i++;
      if (sb.size() > 0) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({touch0, busy0, done0, press0} !== {3'b100, 8'd0}) begin
      bad++; $display("FAIL rst_async got=%b/%0d exp=100/0", {touch0, busy0, done0}, press0);
    end
    @(negedge clk); rst = 1'b0;
    ep0 = 0; ep1 = 0;
    for (int c = 0; c < 30; c++) begin
      total++;
      if ({touch0, busy0, done0} !== 3'b100) begin
        bad++; $display("FAIL rst_after cyc=%0d got=%b exp=100", c, {touch0, busy0, done0});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    hold1 = 16'd1; gap1 = 16'd0;
    for (int s = 0; s < 256; s++) begin push_seq(0, 1, 0); ep1 = ep1 + 8'd1; end
    push_one(1'b1, 1'b0, 1'b0);
    start1 = 1'b1;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if ({touch1, busy1, done1} !== e) begin
        bad++; $display("FAIL b2b_wave cyc=%0d got=%b exp=%b", i + 1, {touch1, busy1, done1}, e);
      end
      if (sb.size() == 2) start1 = 1'b0;
      i++; @(negedge clk);
    end
    total++;
    if (press1 !== ep1) begin bad++; $display("FAIL b2b_press got=%0d exp=%0d", press1, ep1); end
  endtask

  initial begin
    test_reset();
    test_clean_edges();
    test_bounce();
    test_zero_hold_ignore_start();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
